// File: rtl/writeback_buffer_pkg.sv
// Shared types and default geometry for the cache write-back buffer.
package writeback_buffer_pkg;

   localparam int unsigned CACHE_T = 22;
   localparam int unsigned CACHE_S = 6;
   localparam int unsigned CACHE_B = 4;
   localparam int unsigned WORD_W  = 32;

   typedef enum logic [1:0] {
      WB_EMPTY = 2'd0,
      WB_FILL  = 2'd1,
      WB_DRAIN = 2'd2
   } wb_state_e;

   // One memory-port transaction as driven towards main memory
   typedef struct packed {
      logic              write_en;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/writeback_buffer_drain_picker.sv
// Lowest-set-bit encoder choosing the next buffered word to drain.
module wb_drain_picker #(
   parameter int unsigned N = 4,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     valid,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the top so the lowest set bit wins
   always_comb begin
      idx = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (valid[i]) idx = IDX_W'(i);
      end
   end

   assign any = |valid;

endmodule

// File: rtl/writeback_buffer.sv
// One-line write-back buffer between cache and memory; define WB_FORWARD_EN
// to forward reads that hit buffered words instead of stalling them.
module writeback_buffer
   import writeback_buffer_pkg::*;
#(
   parameter int unsigned TAG_WIDTH    = CACHE_T,
   parameter int unsigned SET_WIDTH    = CACHE_S,
   parameter int unsigned OFFSET_WIDTH = CACHE_B
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              write_en_i,
   input  logic [WORD_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o,
   output logic              stall_o,
   output logic              busy_o,
   output logic              mem_write_en_o,
   output logic [WORD_W-1:0] mem_addr_o,
   output logic [WORD_W-1:0] mem_wdata_o,
   input  logic [WORD_W-1:0] mem_rdata_i
);

   localparam int unsigned LINE_W    = TAG_WIDTH + SET_WIDTH;
   localparam int unsigned OFF_W     = OFFSET_WIDTH - 2;
   localparam int unsigned LINE_SIZE = 2 ** OFF_W;

   wb_state_e             state_q, state_d;
   logic [LINE_W-1:0]     line_addr_q, line_addr_d;
   logic [LINE_SIZE-1:0]  valid_q, valid_d;
   logic [WORD_W-1:0]     data_q [LINE_SIZE];

   logic [OFF_W-1:0]      off;
   logic [OFF_W-1:0]      pick_idx;
   logic                  pick_any;
   logic                  wr, rd, match, hit, rd_mem;
   logic                  capture, drain_go;
   mem_req_t              mem_req;
   logic                  unused_addr_bits;

   assign off    = addr_i[OFFSET_WIDTH-1:2];
   assign wr     = req_i & write_en_i;
   assign rd     = req_i & ~write_en_i;
   assign match  = (addr_i[WORD_W-1:OFFSET_WIDTH] == line_addr_q);
   assign hit    = (state_q != WB_EMPTY) & match & valid_q[off];
   assign rd_mem = rd & ~hit;

   assign unused_addr_bits = ^addr_i[1:0];

   wb_drain_picker #(
      .N (LINE_SIZE)
   ) u_picker (
      .valid (valid_q),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Next-state, stall and memory-port arbitration
   always_comb begin
      state_d     = state_q;
      line_addr_d = line_addr_q;
      valid_d     = valid_q;
      capture     = 1'b0;
      drain_go    = 1'b0;
      stall_o     = 1'b0;
      rdata_o     = mem_rdata_i;
      mem_req     = '0;

      unique case (state_q)
         WB_EMPTY: begin
            if (wr) begin
               capture     = 1'b1;
               line_addr_d = addr_i[WORD_W-1:OFFSET_WIDTH];
               state_d     = WB_FILL;
            end
         end
         WB_FILL: begin
            if (wr && match) begin
               capture = 1'b1;
            end else begin
               stall_o = wr;
               state_d = WB_DRAIN;
            end
         end
         WB_DRAIN: begin
            stall_o  = wr;
            drain_go = pick_any & ~rd_mem;
         end
         default: state_d = WB_EMPTY;
      endcase

      if (rd && hit) begin
`ifdef WB_FORWARD_EN
         rdata_o = data_q[off];
`else
         stall_o = 1'b1;
`endif
      end

      if (rd_mem) mem_req.addr = {addr_i[WORD_W-1:2], 2'b00};

      if (capture) valid_d[off] = 1'b1;

      // Drain the lowest valid word; leave for EMPTY on the edge it clears the last one
      if (drain_go) begin
         mem_req.write_en  = 1'b1;
         mem_req.addr      = {line_addr_q, pick_idx, 2'b00};
         mem_req.wdata     = data_q[pick_idx];
         valid_d[pick_idx] = 1'b0;
         if (valid_d == '0) state_d = WB_EMPTY;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= WB_EMPTY;
         line_addr_q <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         line_addr_q <= line_addr_d;
         valid_q     <= valid_d;
      end
   end

   // Word storage needs no reset; valid bits gate every use
   always_ff @(posedge clk_i) begin
      if (capture) data_q[off] <= wdata_i;
   end

   assign busy_o         = |valid_q;
   assign mem_write_en_o = mem_req.write_en;
   assign mem_addr_o     = mem_req.addr;
   assign mem_wdata_o    = mem_req.wdata;

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer against a coherent-memory reference.
`timescale 1ns/1ps
module tb_writeback_buffer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        write_en_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        busy_o;
   logic        mem_write_en_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   int n_vec = 0;
   int n_err = 0;

   logic        mem_clear;
   logic [31:0] tb_mem [256];
   logic [31:0] golden [256];

   writeback_buffer #(
      .TAG_WIDTH    (22),
      .SET_WIDTH    (6),
      .OFFSET_WIDTH (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_i          (req_i),
      .write_en_i     (write_en_i),
      .addr_i         (addr_i),
      .wdata_i        (wdata_i),
      .rdata_o        (rdata_o),
      .stall_o        (stall_o),
      .busy_o         (busy_o),
      .mem_write_en_o (mem_write_en_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rdata_i    (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] init_val(input int i);
      return {16'hC0DE, 8'(i), 8'(~i)};
   endfunction

   // Main memory: combinational read, write on the strobe
   assign mem_rdata_i = tb_mem[mem_addr_o[9:2]];
   always @(posedge clk_i) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(i);
      end else if (mem_write_en_o) begin
         tb_mem[mem_addr_o[9:2]] <= mem_wdata_o;
      end
   end

   task automatic drive(input logic rq, input logic we, input logic [31:0] a, input logic [31:0] d);
      req_i = rq; write_en_i = we; addr_i = a; wdata_i = d;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_o); end
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_vec++; if (mem_write_en_o !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %b want 0", mem_write_en_o); end
      n_vec++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
      n_vec++; if (mem_wdata_o !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", mem_wdata_o); end
      n_vec++; if (rdata_o !== golden[0]) begin n_err++; $display("FAIL reset_rdata: got %h want %h", rdata_o, golden[0]); end
      tick();
   endtask

   task automatic test_drain_line();
      logic [31:0] a [4];
      for (int k = 0; k < 4; k++) begin
         a[k] = $urandom;
         drive(1'b1, 1'b1, 32'h100 + 32'(4 * k), a[k]);
         @(negedge clk_i);
         n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL fill_stall[%0d]: got %b want 0", k, stall_o); end
         golden[64 + k] = a[k];
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      n_vec++; if (mem_write_en_o !== 1'b0) begin n_err++; $display("FAIL fill_exit_wen: got %b want 0", mem_write_en_o); end
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         n_vec++; if (mem_write_en_o !== 1'b1) begin n_err++; $display("FAIL drain_wen[%0d]: got %b want 1", k, mem_write_en_o); end
         n_vec++; if (mem_addr_o !== 32'h100 + 32'(4 * k)) begin n_err++; $display("FAIL drain_addr[%0d]: got %h want %h", k, mem_addr_o, 32'h100 + 32'(4 * k)); end
         n_vec++; if (mem_wdata_o !== a[k]) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", k, mem_wdata_o, a[k]); end
         n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL drain_busy[%0d]: got %b want 1", k, busy_o); end
         n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL drain_stall[%0d]: got %b want 0", k, stall_o); end
         tick();
      end
      @(negedge clk_i);
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL drain_done_busy: got %b want 0", busy_o); end
      n_vec++; if (mem_write_en_o !== 1'b0) begin n_err++; $display("FAIL drain_done_wen: got %b want 0", mem_write_en_o); end
      tick();
   endtask

   task automatic test_read_during_drain();
      logic [31:0] b [4];
      for (int k = 0; k < 4; k++) begin
         b[k] = $urandom;
         drive(1'b1, 1'b1, 32'h100 + 32'(4 * k), b[k]);
         golden[64 + k] = b[k];
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, 32'h200 + 32'(4 * k), 32'h0);
         @(negedge clk_i);
         n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL rd_stall[%0d]: got %b want 0", k, stall_o); end
         n_vec++; if (rdata_o !== golden[128 + k]) begin n_err++; $display("FAIL rd_data[%0d]: got %h want %h", k, rdata_o, golden[128 + k]); end
         n_vec++; if (mem_write_en_o !== 1'b0) begin n_err++; $display("FAIL rd_wen[%0d]: got %b want 0", k, mem_write_en_o); end
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         n_vec++; if (mem_write_en_o !== 1'b1 || mem_addr_o !== 32'h100 + 32'(4 * k) || mem_wdata_o !== b[k]) begin
            n_err++; $display("FAIL rd_drain[%0d]: got en=%b addr=%h data=%h want 1 %h %h", k, mem_write_en_o, mem_addr_o, mem_wdata_o, 32'h100 + 32'(4 * k), b[k]);
         end
         tick();
      end
      @(negedge clk_i);
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rd_drain_busy: got %b want 0", busy_o); end
      tick();
   endtask

   task automatic test_forward();
      logic [31:0] c [4];
      for (int k = 0; k < 4; k++) begin
         c[k] = $urandom;
         drive(1'b1, 1'b1, 32'h100 + 32'(4 * k), c[k]);
         golden[64 + k] = c[k];
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      drive(1'b1, 1'b0, 32'h108, 32'h0);
`ifdef WB_FORWARD_EN
      @(negedge clk_i);
      n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL fwd_stall: got %b want 0", stall_o); end
      n_vec++; if (rdata_o !== c[2]) begin n_err++; $display("FAIL fwd_data: got %h want %h", rdata_o, c[2]); end
      n_vec++; if (mem_write_en_o !== 1'b1 || mem_addr_o !== 32'h100) begin n_err++; $display("FAIL fwd_drain: got en=%b addr=%h want 1 100", mem_write_en_o, mem_addr_o); end
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk_i);
         n_vec++; if (mem_write_en_o !== 1'b1 || mem_addr_o !== 32'h100 + 32'(4 * k)) begin n_err++; $display("FAIL fwd_rest[%0d]: got en=%b addr=%h", k, mem_write_en_o, mem_addr_o); end
         tick();
      end
`else
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL nofwd_stall[%0d]: got %b want 1", k, stall_o); end
         n_vec++; if (mem_write_en_o !== 1'b1 || mem_addr_o !== 32'h100 + 32'(4 * k)) begin n_err++; $display("FAIL nofwd_drain[%0d]: got en=%b addr=%h", k, mem_write_en_o, mem_addr_o); end
         tick();
      end
      @(negedge clk_i);
      n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL nofwd_release: got %b want 0", stall_o); end
      n_vec++; if (rdata_o !== c[2]) begin n_err++; $display("FAIL nofwd_data: got %h want %h", rdata_o, c[2]); end
      n_vec++; if (mem_write_en_o !== 1'b0) begin n_err++; $display("FAIL nofwd_wen: got %b want 0", mem_write_en_o); end
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      n_vec++; if (mem_write_en_o !== 1'b1 || mem_addr_o !== 32'h10C) begin n_err++; $display("FAIL nofwd_last: got en=%b addr=%h", mem_write_en_o, mem_addr_o); end
      tick();
`endif
      @(negedge clk_i);
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL fwd_busy: got %b want 0", busy_o); end
      tick();
   endtask

   task automatic test_write_during_drain();
      logic [31:0] d [4];
      logic [31:0] e;
      for (int k = 0; k < 4; k++) begin
         d[k] = $urandom;
         drive(1'b1, 1'b1, 32'h100 + 32'(4 * k), d[k]);
         golden[64 + k] = d[k];
         tick();
      end
      e = $urandom;
      drive(1'b1, 1'b1, 32'h300, e);
      @(negedge clk_i);
      n_vec++; if (stall_o !== 1'b1 || mem_write_en_o !== 1'b0) begin n_err++; $display("FAIL wd_conflict: got stall=%b en=%b want 1 0", stall_o, mem_write_en_o); end
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL wd_stall[%0d]: got %b want 1", k, stall_o); end
         n_vec++; if (mem_write_en_o !== 1'b1 || mem_addr_o !== 32'h100 + 32'(4 * k) || mem_wdata_o !== d[k]) begin
            n_err++; $display("FAIL wd_drain[%0d]: got en=%b addr=%h data=%h", k, mem_write_en_o, mem_addr_o, mem_wdata_o);
         end
         tick();
      end
      @(negedge clk_i);
      n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL wd_accept: got stall=%b want 0", stall_o); end
      golden[192] = e;
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      n_vec++; if (busy_o !== 1'b1 || mem_write_en_o !== 1'b0) begin n_err++; $display("FAIL wd_captured: got busy=%b en=%b want 1 0", busy_o, mem_write_en_o); end
      tick();
      @(negedge clk_i);
      n_vec++; if (mem_write_en_o !== 1'b1 || mem_addr_o !== 32'h300 || mem_wdata_o !== e) begin
         n_err++; $display("FAIL wd_new_drain: got en=%b addr=%h data=%h want 1 300 %h", mem_write_en_o, mem_addr_o, mem_wdata_o, e);
      end
      tick();
   endtask

   task automatic test_reset_mid_fill();
      drive(1'b1, 1'b1, 32'h100, $urandom);
      tick();
      drive(1'b1, 1'b1, 32'h104, $urandom);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      rst_i = 1'b1;
      @(negedge clk_i);
      n_vec++; if (mem_write_en_o !== 1'b0) begin n_err++; $display("FAIL rst_fill_wen: got %b want 0", mem_write_en_o); end
      tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_fill_busy: got %b want 0", busy_o); end
      for (int k = 0; k < 6; k++) begin
         n_vec++; if (mem_write_en_o !== 1'b0) begin n_err++; $display("FAIL rst_fill_nowrite[%0d]: got %b want 0", k, mem_write_en_o); end
         tick();
         @(negedge clk_i);
      end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] lines [4];
      logic [31:0] a, dat;
      logic        we;
      int          r, waited;
      bit          accepted;
      lines[0] = 32'h100; lines[1] = 32'h110; lines[2] = 32'h200; lines[3] = 32'h210;
      for (int t = 0; t < 400; t++) begin
         r = int'($urandom_range(0, 3));
         if (r == 0) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            tick();
         end else begin
            we  = (r == 1);
            a   = lines[$urandom_range(0, 3)] + 32'(4 * $urandom_range(0, 3));
            dat = $urandom;
            drive(1'b1, we, a, dat);
            waited   = 0;
            accepted = 1'b0;
            while (!accepted && waited < 50) begin
               @(negedge clk_i);
               if (!stall_o) begin
                  accepted = 1'b1;
                  if (we) begin
                     golden[a[9:2]] = dat;
                  end else begin
                     n_vec++;
                     if (rdata_o !== golden[a[9:2]]) begin n_err++; $display("FAIL rand_read t=%0d addr=%h: got %h want %h", t, a, rdata_o, golden[a[9:2]]); end
                  end
               end else begin
                  waited++;
               end
               tick();
            end
            n_vec++;
            if (!accepted) begin n_err++; $display("FAIL rand_accept t=%0d addr=%h: stalled %0d cycles, want accepted", t, a, waited); end
         end
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      waited = 0;
      @(negedge clk_i);
      while (busy_o && waited < 20) begin
         tick();
         @(negedge clk_i);
         waited++;
      end
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rand_drain_end: busy=%b after %0d cycles, want 0", busy_o, waited); end
      tick();
      tick();
      for (int i = 0; i < 256; i++) begin
         n_vec++;
         if (tb_mem[i] !== golden[i]) begin n_err++; $display("FAIL mem_image[%0d]: got %h want %h", i, tb_mem[i], golden[i]); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1;
      mem_clear = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 256; i++) golden[i] = init_val(i);
      tick();
      tick();
      mem_clear = 1'b0;
      test_reset();
      test_drain_line();
      test_read_during_drain();
      test_forward();
      test_write_during_drain();
      test_reset_mid_fill();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
